// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: default widths, ROM entry layout,
// the END marker and the sequencer state encoding.
package song_pkg;

  localparam int unsigned DEF_SONG_BITS = 2;
  localparam int unsigned DEF_IDX_BITS  = 7;
  localparam int unsigned DEF_NOTE_W    = 6;
  localparam int unsigned DEF_DUR_W     = 6;

  localparam int unsigned IS_WAIT_BIT = 15;
  localparam int unsigned NOTE_MSB    = 14;
  localparam int unsigned NOTE_LSB    = 9;
  localparam int unsigned DUR_MSB     = 8;
  localparam int unsigned DUR_LSB     = 3;

  // bits [2:0] are don't-care, so END is matched on [15:3] only
  localparam logic [15:0] END_MARKER = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_REST   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/song_reader_beat_rest_counter.sv
// Loadable beat down-counter for WAIT entries; expire flags the enabled
// beat that takes the count from 1 to 0.
module beat_rest_counter #(
  parameter int unsigned DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [DUR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == DUR_W'(1));

endmodule

// File: rtl/song_reader.sv
// Song sequencer: walks NOTE/WAIT/END entries of an external synchronous song
// ROM and issues load strobes to the note distributor.
module song_reader
  import song_pkg::*;
#(
  parameter int unsigned SONG_BITS = DEF_SONG_BITS,
  parameter int unsigned IDX_BITS  = DEF_IDX_BITS,
  parameter int unsigned NOTE_W    = DEF_NOTE_W,
  parameter int unsigned DUR_W     = DEF_DUR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          beat,
  input  logic [SONG_BITS-1:0]          song,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic                          load_new_note,
  output logic [NOTE_W-1:0]             note_to_load,
  output logic [DUR_W-1:0]              duration_to_load,
  output logic                          song_done,
  output logic                          busy
);

  state_e               state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 entry_wait, entry_end, last_idx, advance;
  logic [NOTE_W-1:0]    entry_note;
  logic [DUR_W-1:0]     entry_dur;
  logic                 rest_clear, rest_load, rest_en, rest_expire;
  logic                 unused_low_bits;

  assign entry_wait      = rom_data[IS_WAIT_BIT];
  assign entry_note      = rom_data[NOTE_MSB:NOTE_LSB];
  assign entry_dur       = rom_data[DUR_MSB:DUR_LSB];
  assign entry_end       = (rom_data[IS_WAIT_BIT:DUR_LSB] == END_MARKER[IS_WAIT_BIT:DUR_LSB]);
  assign unused_low_bits = ^rom_data[DUR_LSB-1:0];
  assign last_idx        = &idx_q;
  assign rest_en         = beat && play && (state_q == S_REST);

  beat_rest_counter #(.DUR_W(DUR_W)) u_rest (
    .clk      (clk),
    .reset    (reset),
    .clear    (rest_clear),
    .load     (rest_load),
    .load_val (entry_dur),
    .en       (rest_en),
    .expire   (rest_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    song_d     = song_q;
    note_d     = note_q;
    dur_d      = dur_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    rest_clear = 1'b0;
    rest_load  = 1'b0;
    advance    = 1'b0;

    if (song != song_q) begin
      // a song change pre-empts everything, including a DECODE in flight
      song_d     = song;
      idx_d      = '0;
      rest_clear = 1'b1;
      state_d    = play ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d = '0;
          if (play) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (play) state_d = S_DECODE;
        end
        S_DECODE: begin
          if (entry_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!entry_wait) begin
            load_d  = 1'b1;
            note_d  = entry_note;
            dur_d   = entry_dur;
            advance = 1'b1;
          end else if (entry_dur != '0) begin
            rest_load = 1'b1;
            state_d   = S_REST;
          end else begin
            advance = 1'b1;
          end
        end
        S_REST: begin
          if (rest_expire) advance = 1'b1;
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // advancing past the last index ends the song instead of wrapping
      if (advance) begin
        if (last_idx) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_REST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rom_addr         = {song_q, idx_q};
  assign load_new_note    = load_q;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign song_done        = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed song table, wrap and song-change/reset
// sequences, and random songs against an event-schedule reference model.
module tb_song_reader;

  localparam int MAXP = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic        beat = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        load_new_note;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        song_done;
  logic        busy;

  song_reader #(.SONG_BITS(2), .IDX_BITS(7), .NOTE_W(6), .DUR_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .beat             (beat),
    .song             (song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .song_done        (song_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:511];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  // per-period stimulus and expected events (period 0 = first period with play=1)
  bit         play_at [MAXP];
  bit         beat_at [MAXP];
  bit         exp_load [MAXP];
  logic [5:0] exp_note [MAXP];
  logic [5:0] exp_dur  [MAXP];
  int         exp_done_t;

  int         obs_t [$];
  logic [5:0] obs_n [$];
  logic [5:0] obs_d [$];
  int         obs_done_t;

  typedef struct {
    logic [15:0] e0, e1, e2;
    int          beat_per, pause_lo, pause_hi;
    int          n_str;
    int          s1_t; logic [5:0] s1_n, s1_d;
    int          s2_t; logic [5:0] s2_n, s2_d;
    int          done_t;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [15:0] mk_note(input logic [5:0] n, input logic [5:0] d);
    return {1'b0, n, d, 3'b000};
  endfunction

  function automatic logic [15:0] mk_wait(input logic [5:0] d, input logic [5:0] junk, input logic [2:0] lo);
    return {1'b1, junk, d, lo};
  endfunction

  function automatic vec_t mkvec(input logic [15:0] e0, e1, e2, input int bp, plo, phi, n,
                                 input int s1t, input logic [5:0] s1n, s1d,
                                 input int s2t, input logic [5:0] s2n, s2d, input int dt);
    vec_t v;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.beat_per = bp; v.pause_lo = plo; v.pause_hi = phi; v.n_str = n;
    v.s1_t = s1t; v.s1_n = s1n; v.s1_d = s1d;
    v.s2_t = s2t; v.s2_n = s2n; v.s2_d = s2d; v.done_t = dt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    play = 1'b0; beat = 1'b0; song = 2'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", load_new_note, 1'b0);
    chk("rst_done", song_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", rom_addr, 9'h000);
    chk("rst_note", {duration_to_load, note_to_load}, 12'h000);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Walks song 0 entry by entry: a fetch needs a playing period, decode takes
  // one more, a NOTE lands two periods after its fetch, a WAIT consumes beats
  // that coincide with play, and the next fetch follows the last counted beat.
  task automatic model();
    int n, nxt, idx, cnt, p;
    logic [15:0] e;
    bit stop;
    for (int t = 0; t < MAXP; t++) begin
      exp_load[t] = 1'b0; exp_note[t] = '0; exp_dur[t] = '0;
    end
    exp_done_t = MAXP;
    n = 1; idx = 0; stop = 1'b0;
    while (!stop) begin
      while (n < MAXP && !play_at[n]) n++;
      if (n >= MAXP - 4) break;
      e = mem[idx];
      nxt = n + 2;
      if (!e[15] && e[14:3] == 13'd0) begin
        exp_done_t = n + 2;
        break;
      end
      if (!e[15]) begin
        exp_load[n+2] = 1'b1; exp_note[n+2] = e[14:9]; exp_dur[n+2] = e[8:3];
      end else if (e[8:3] != 6'd0) begin
        cnt = int'(e[8:3]);
        p = n + 2;
        while (cnt > 0 && p < MAXP - 4) begin
          if (beat_at[p] && play_at[p]) cnt--;
          p++;
        end
        if (cnt > 0) break;
        nxt = p;
      end
      if (idx == 127) begin
        exp_done_t = nxt;
        stop = 1'b1;
      end else begin
        idx++;
        n = nxt;
      end
    end
  endtask

  task automatic run_scn();
    int last;
    logic [5:0] hn, hd;
    model();
    for (int t = 0; t < MAXP; t++) if (t >= exp_done_t) play_at[t] = 1'b1;
    last = (exp_done_t < MAXP - 8) ? exp_done_t + 3 : MAXP - 8;
    obs_t.delete(); obs_n.delete(); obs_d.delete();
    obs_done_t = -1;
    hn = '0; hd = '0;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      play = play_at[t];
      beat = beat_at[t];
      @(negedge clk);
      if (exp_load[t]) begin hn = exp_note[t]; hd = exp_dur[t]; end
      chk("load_new_note", load_new_note, exp_load[t]);
      chk("song_done", song_done, t == exp_done_t);
      chk("busy", busy, (t >= 1) && (t < exp_done_t));
      chk("note_to_load", note_to_load, hn);
      chk("duration_to_load", duration_to_load, hd);
      if (load_new_note) begin obs_t.push_back(t); obs_n.push_back(note_to_load); obs_d.push_back(duration_to_load); end
      if (song_done && obs_done_t < 0) obs_done_t = t;
    end
    play = 1'b0;
    beat = 1'b0;
  endtask

  initial begin
    int r, len;

    tbl[0] = mkvec(mk_note(6'd12, 6'd8), mk_note(6'd16, 6'd8), 16'h0000, 0, 0, 0,
                   2, 3, 6'd12, 6'd8, 5, 6'd16, 6'd8, 7);
    tbl[1] = mkvec(mk_wait(6'd3, 6'd0, 3'd0), mk_note(6'd20, 6'd4), 16'h0000, 10, 0, 0,
                   1, 33, 6'd20, 6'd4, -1, 6'd0, 6'd0, 35);
    tbl[2] = mkvec(mk_wait(6'd5, 6'd0, 3'd0), mk_note(6'd7, 6'd2), 16'h0000, 10, 25, 46,
                   1, 73, 6'd7, 6'd2, -1, 6'd0, 6'd0, 75);
    tbl[3] = mkvec(mk_wait(6'd0, 6'd33, 3'd5), mk_note(6'd0, 6'd5), 16'h0007, 0, 0, 0,
                   1, 5, 6'd0, 6'd5, -1, 6'd0, 6'd0, 7);
    tbl[4] = mkvec(16'h0000, mk_note(6'd9, 6'd9), 16'h0000, 0, 0, 0,
                   0, -1, 6'd0, 6'd0, -1, 6'd0, 6'd0, 3);
    tbl[5] = mkvec(mk_note(6'd3, 6'd2), mk_note(6'd4, 6'd6), 16'h0000, 0, 2, 4,
                   2, 3, 6'd3, 6'd2, 6, 6'd4, 6'd6, 8);

    for (int v = 0; v < 6; v++) begin
      clear_mem();
      mem[0] = tbl[v].e0; mem[1] = tbl[v].e1; mem[2] = tbl[v].e2;
      for (int t = 0; t < MAXP; t++) begin
        beat_at[t] = (tbl[v].beat_per > 0) && (t > 0) && (t % tbl[v].beat_per == 0);
        play_at[t] = !((t >= tbl[v].pause_lo) && (t < tbl[v].pause_hi));
      end
      do_reset();
      run_scn();
      chk("tbl_strobe_count", obs_t.size(), tbl[v].n_str);
      if (tbl[v].n_str > 0 && obs_t.size() > 0) begin
        chk("tbl_s1_period", obs_t[0], tbl[v].s1_t);
        chk("tbl_s1_note", obs_n[0], tbl[v].s1_n);
        chk("tbl_s1_dur", obs_d[0], tbl[v].s1_d);
      end
      if (tbl[v].n_str > 1 && obs_t.size() > 1) begin
        chk("tbl_s2_period", obs_t[1], tbl[v].s2_t);
        chk("tbl_s2_note", obs_n[1], tbl[v].s2_n);
        chk("tbl_s2_dur", obs_d[1], tbl[v].s2_d);
      end
      chk("tbl_done_period", obs_done_t, tbl[v].done_t);
    end

    // 128 NOTEs and no END: the last index ends the song without wrapping
    clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = mk_note(6'(i % 64), 6'(1 + i % 60));
    for (int t = 0; t < MAXP; t++) begin beat_at[t] = 1'b0; play_at[t] = 1'b1; end
    do_reset();
    run_scn();
    chk("wrap_strobe_count", obs_t.size(), 128);
    chk("wrap_done_period", obs_done_t, 257);
    chk("wrap_addr_held", rom_addr, 9'd127);

    // song change during DECODE of a NOTE
    clear_mem();
    mem[0] = mk_note(6'd5, 6'd5);
    mem[256] = mk_note(6'd9, 6'd3);
    do_reset();
    @(posedge clk); #1 play = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 song = 2'd2;
    @(posedge clk); #1;
    chk("chg_no_strobe", load_new_note, 1'b0);
    chk("chg_addr", rom_addr, 9'h100);
    chk("chg_note_kept", note_to_load, 6'd0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("chg_strobe", load_new_note, 1'b1);
    chk("chg_note", {note_to_load, duration_to_load}, {6'd9, 6'd3});
    @(posedge clk);
    @(posedge clk); #1;
    chk("chg_done", song_done, 1'b1);

    // asynchronous reset during a strobe
    clear_mem();
    mem[0] = mk_note(6'd12, 6'd8);
    do_reset();
    @(posedge clk); #1 play = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_strobe", load_new_note, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_load", load_new_note, 1'b0);
    chk("ar_note", {note_to_load, duration_to_load}, 12'h000);
    chk("ar_addr", rom_addr, 9'h000);
    chk("ar_busy", busy, 1'b0);
    play = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ar_idle", busy, 1'b0);

    // asynchronous reset during REST of song 1
    clear_mem();
    mem[128] = mk_wait(6'd5, 6'd0, 3'd0);
    do_reset();
    @(posedge clk); #1 begin song = 2'd1; play = 1'b1; end
    repeat (6) @(posedge clk);
    #1;
    chk("rr_busy", busy, 1'b1);
    chk("rr_addr", rom_addr, 9'h080);
    #2 reset = 1'b0;
    #1;
    chk("rr_addr0", rom_addr, 9'h000);
    chk("rr_busy0", busy, 1'b0);
    play = 1'b0; song = 2'd0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rr_idle", busy, 1'b0);

    // random songs, beats and pauses
    for (int k = 0; k < 8; k++) begin
      clear_mem();
      for (int i = 0; i < 128; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          mem[i] = mk_note(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
          if (mem[i][14:3] == 12'd0) mem[i][3] = 1'b1;
          mem[i][2:0] = 3'($urandom_range(0, 7));
        end else begin
          mem[i] = mk_wait(6'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
        end
      end
      len = $urandom_range(3, 40);
      if (k != 0) mem[len] = 16'(3'($urandom_range(0, 7)));
      for (int t = 0; t < MAXP; t++) begin
        beat_at[t] = ($urandom_range(0, 2) == 0);
        play_at[t] = (t == 0) || ($urandom_range(0, 9) != 0);
      end
      do_reset();
      run_scn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
